// File: rtl/act_c2_pipe_mux.sv
// rtl/act_c2_pipe_mux.sv - gated-select 4:1 word mux with elastic output pipeline and usage counters
//
// Purpose:
//   Forms two select bits from gate inputs (A0/B0 and A1/B1, AND or OR per
//   S*_MODE), picks one of four WIDTH-bit words, and carries the chosen word
//   plus its select code through a PIPE-stage valid/ready pipeline. A per-input
//   saturating counter records how many accepted transfers used each input.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   D00, D01, D10, D11       candidate data words, indexed by {s1,s0}
//   A0, B0, A1, B1           select gate inputs
//   in_valid / in_ready      input handshake
//   out, out_sel, out_valid  pipeline tail: word, select code, valid
//   out_ready                downstream accept
//   clr_cnt                  synchronous clear of the usage counters
//   cnt00..cnt11             saturating transfer counts per selected input

module act_c2_pipe_mux #(
    parameter int WIDTH   = 8,
    parameter int PIPE    = 2,
    parameter int S0_MODE = 0,
    parameter int S1_MODE = 1,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   D00,
    input  logic [WIDTH-1:0]   D01,
    input  logic [WIDTH-1:0]   D10,
    input  logic [WIDTH-1:0]   D11,
    input  logic               A0,
    input  logic               B0,
    input  logic               A1,
    input  logic               B1,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               clr_cnt,
    output logic [COUNT_W-1:0] cnt00,
    output logic [COUNT_W-1:0] cnt01,
    output logic [COUNT_W-1:0] cnt10,
    output logic [COUNT_W-1:0] cnt11
);

    // ------------------------------------------------------------------
    // Select formation and word mux
    // ------------------------------------------------------------------
    logic             s0;
    logic             s1;
    logic [1:0]       sel_in;
    logic [WIDTH-1:0] word_in;

    assign s0     = (S0_MODE != 0) ? (A0 | B0) : (A0 & B0);
    assign s1     = (S1_MODE != 0) ? (A1 | B1) : (A1 & B1);
    assign sel_in = {s1, s0};

    always_comb begin
        word_in = D00;
        case (sel_in)
            2'b00:   word_in = D00;
            2'b01:   word_in = D01;
            2'b10:   word_in = D10;
            default: word_in = D11;
        endcase
    end

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------
    logic [PIPE-1:0]  v_q;
    logic [WIDTH-1:0] data_q [PIPE];
    logic [1:0]       sel_q  [PIPE];

    // Candidate contents for each stage when it loads: stage 0 takes the
    // input, every later stage takes the stage in front of it.
    logic [PIPE-1:0]  v_d;
    logic [WIDTH-1:0] data_d [PIPE];
    logic [1:0]       sel_d  [PIPE];

    logic [PIPE-1:0]  load;
    logic             full_chain;
    logic             in_xfer;

    always_comb begin
        v_d       = '0;
        v_d[0]    = in_valid;
        data_d[0] = word_in;
        sel_d[0]  = sel_in;
        for (int k = 1; k < PIPE; k++) begin
            v_d[k]    = v_q[k-1];
            data_d[k] = data_q[k-1];
            sel_d[k]  = sel_q[k-1];
        end
    end

    // Ready path, tail to head. A stage may load unless it and every stage
    // behind it (towards the tail) are full while the tail is stalled. This
    // is the unrolled form of "empty OR next stage loads", written as a
    // running AND so no signal feeds back on itself.
    always_comb begin
        load       = '0;
        full_chain = ~out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            full_chain = full_chain & v_q[k];
            load[k]    = ~full_chain;
        end
    end

    assign in_ready = load[0];
    assign in_xfer  = in_valid & in_ready;

    // Data/select registers only capture when a valid word moves in, so a
    // bubble passing through leaves the previous payload untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                data_q[k] <= '0;
                sel_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_d[k];
                    if (v_d[k]) begin
                        data_q[k] <= data_d[k];
                        sel_q[k]  <= sel_d[k];
                    end
                end
            end
        end
    end

    assign out       = data_q[PIPE-1];
    assign out_sel   = sel_q[PIPE-1];
    assign out_valid = v_q[PIPE-1];

    // ------------------------------------------------------------------
    // Usage counters
    // ------------------------------------------------------------------
    logic [COUNT_W-1:0] cnt_q [4];

    // clr_cnt wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (in_xfer && (cnt_q[sel_in] != {COUNT_W{1'b1}})) begin
            cnt_q[sel_in] <= cnt_q[sel_in] + 1'b1;
        end
    end

    assign cnt00 = cnt_q[0];
    assign cnt01 = cnt_q[1];
    assign cnt10 = cnt_q[2];
    assign cnt11 = cnt_q[3];

endmodule
